// File: rtl/sbn_pkg.sv
// Shared definitions for the SBN loader: FSM state encoding, stream command bytes
// and default operand/data widths.
package sbn_pkg;

  localparam int FWIDTH_DEF = 8;
  localparam int DWIDTH_DEF = 32;

  localparam logic [7:0] CMD_LDI = 8'h01;
  localparam logic [7:0] CMD_LDD = 8'h02;
  localparam logic [7:0] CMD_RUN = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CNT,
    DATA,
    CHK,
    RUN,
    ERR
  } state_t;

endpackage

// File: rtl/sbn_word_asm.sv
// Big-endian word assembler: shifts in NBYTES bytes MSB first, flags the final byte
// combinationally (last) and pulses done on the following cycle with the word valid.
module sbn_word_asm #(
  parameter int NBYTES = 4,
  parameter int OWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_en,
  output logic [OWIDTH-1:0] word,
  output logic              last,
  output logic              done
);

  localparam int SW = NBYTES * 8;
  localparam int CW = $clog2(NBYTES + 1);

  logic [SW-1:0] sr;
  logic [CW-1:0] cnt;

  assign last = byte_en && (cnt == CW'(NBYTES - 1));
  assign word = sr[OWIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (byte_en) begin
        sr  <= SW'({sr, byte_in});
        cnt <= last ? '0 : cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sbn_loader.sv
// Byte-stream loader for the SBN machine: decodes load/run frames into memory writes.
// Optional trailing per-frame checksum byte is enabled by defining SBN_LOADER_CHKSUM_EN.
module sbn_loader
  import sbn_pkg::*;
#(
  parameter int fwidth = FWIDTH_DEF,
  parameter int dwidth = DWIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  im_we,
  output logic [fwidth-1:0]     im_addr,
  output logic [4*fwidth-1:0]   im_wdata,
  output logic                  dm_we,
  output logic [fwidth-1:0]     dm_addr,
  output logic [dwidth-1:0]     dm_wdata,
  output logic                  run,
  input  logic                  halt,
  output logic                  err
);

  localparam int IBYTES = (4 * fwidth + 7) / 8;
  localparam int DBYTES = (dwidth + 7) / 8;

`ifdef SBN_LOADER_CHKSUM_EN
  localparam state_t FRAME_END = CHK;
  logic [7:0] sum;
`else
  localparam state_t FRAME_END = IDLE;
`endif

  state_t            state;
  logic [7:0]        cmd;
  logic [fwidth-1:0] addr;
  logic [fwidth-1:0] count;
  logic [fwidth-1:0] field;
  logic              xfer;
  logic              i_en, d_en, i_last, d_last, word_last;

  assign xfer      = in_valid && in_ready;
  assign field     = in_data[fwidth-1:0];
  assign i_en      = xfer && (state == DATA) && (cmd == CMD_LDI);
  assign d_en      = xfer && (state == DATA) && (cmd == CMD_LDD);
  assign word_last = i_last || d_last;

  sbn_word_asm #(.NBYTES(IBYTES), .OWIDTH(4 * fwidth)) u_iasm (
    .clk(clk), .rst(rst), .byte_in(in_data), .byte_en(i_en),
    .word(im_wdata), .last(i_last), .done(im_we)
  );

  sbn_word_asm #(.NBYTES(DBYTES), .OWIDTH(dwidth)) u_dasm (
    .clk(clk), .rst(rst), .byte_in(in_data), .byte_en(d_en),
    .word(dm_wdata), .last(d_last), .done(dm_we)
  );

  // Write addresses are captured with the final byte so they line up with the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      run      <= 1'b0;
      err      <= 1'b0;
      cmd      <= '0;
      addr     <= '0;
      count    <= '0;
      im_addr  <= '0;
      dm_addr  <= '0;
`ifdef SBN_LOADER_CHKSUM_EN
      sum      <= '0;
`endif
    end else begin
      if (i_last) im_addr <= addr;
      if (d_last) dm_addr <= addr;
`ifdef SBN_LOADER_CHKSUM_EN
      if (xfer) sum <= (state == IDLE) ? in_data : 8'(sum + in_data);
`endif
      case (state)
        IDLE: if (xfer) begin
          cmd <= in_data;
          if (in_data == CMD_LDI || in_data == CMD_LDD) begin
            state <= ADDR;
          end else if (in_data == CMD_RUN) begin
`ifdef SBN_LOADER_CHKSUM_EN
            state <= CHK;
`else
            state    <= RUN;
            in_ready <= 1'b0;
            run      <= 1'b1;
`endif
          end else begin
            state    <= ERR;
            in_ready <= 1'b0;
            err      <= 1'b1;
          end
        end
        ADDR: if (xfer) begin
          addr  <= field;
          state <= CNT;
        end
        CNT: if (xfer) begin
          count <= field;
          state <= (field == '0) ? FRAME_END : DATA;
        end
        DATA: if (word_last) begin
          addr  <= addr + fwidth'(1);
          count <= count - fwidth'(1);
          if (count == fwidth'(1)) state <= FRAME_END;
        end
`ifdef SBN_LOADER_CHKSUM_EN
        CHK: if (xfer) begin
          if (8'(sum + in_data) != 8'h00) begin
            state    <= ERR;
            in_ready <= 1'b0;
            err      <= 1'b1;
          end else if (cmd == CMD_RUN) begin
            state    <= RUN;
            in_ready <= 1'b0;
            run      <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
`endif
        RUN: if (halt) begin
          state    <= IDLE;
          run      <= 1'b0;
          in_ready <= 1'b1;
        end
        ERR: ;
        default: begin
          state    <= ERR;
          in_ready <= 1'b0;
          run      <= 1'b0;
          err      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sbn_loader.sv
// Self-checking bench for sbn_loader: table of byte vectors with expected outputs,
// plus hand-written reset and protocol-error sequences.
module tb_sbn_loader;

  localparam int FW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          im_we;
  logic [FW-1:0] im_addr;
  logic [4*FW-1:0] im_wdata;
  logic          dm_we;
  logic [FW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          run;
  logic          halt;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  sbn_loader #(.fwidth(FW), .dwidth(DW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .run(run), .halt(halt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [7:0]  data;
    logic        halt;
    logic        rdy;
    logic        imwe;
    logic        dmwe;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        run;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(logic r, logic v, logic [7:0] d, logic h, logic rdy,
                               logic iw, logic dw, logic [7:0] a, logic [31:0] w,
                               logic rn, logic e);
    vec_t x;
    x.rst = r; x.valid = v; x.data = d; x.halt = h; x.rdy = rdy;
    x.imwe = iw; x.dmwe = dw; x.addr = a; x.wdata = w; x.run = rn; x.err = e;
    vecs.push_back(x);
  endfunction

  // Shorthands: plain byte, byte completing an imem / dmem word, idle cycle, reset cycle.
  function automatic void b(logic [7:0] d);
    addv(0, 1, d, 0, 1, 0, 0, 8'h00, 32'h0, 0, 0);
  endfunction
  function automatic void bi(logic [7:0] d, logic [7:0] a, logic [31:0] w);
    addv(0, 1, d, 0, 1, 1, 0, a, w, 0, 0);
  endfunction
  function automatic void bd(logic [7:0] d, logic [7:0] a, logic [31:0] w);
    addv(0, 1, d, 0, 1, 0, 1, a, w, 0, 0);
  endfunction
  function automatic void idle();
    addv(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 32'h0, 0, 0);
  endfunction
  function automatic void rstv();
    addv(1, 0, 8'h00, 0, 1, 0, 0, 8'h00, 32'h0, 0, 0);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst      = v.rst;
    in_valid = v.valid;
    in_data  = v.data;
    halt     = v.halt;
    @(negedge clk);
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    cmp({tag, ".in_ready"}, 32'(in_ready), 32'(v.rdy));
    cmp({tag, ".im_we"}, 32'(im_we), 32'(v.imwe));
    cmp({tag, ".dm_we"}, 32'(dm_we), 32'(v.dmwe));
    cmp({tag, ".run"}, 32'(run), 32'(v.run));
    cmp({tag, ".err"}, 32'(err), 32'(v.err));
    if (v.imwe) begin
      cmp({tag, ".im_addr"}, 32'(im_addr), 32'(v.addr));
      cmp({tag, ".im_wdata"}, im_wdata, v.wdata);
    end
    if (v.dmwe) begin
      cmp({tag, ".dm_addr"}, 32'(dm_addr), 32'(v.addr));
      cmp({tag, ".dm_wdata"}, dm_wdata, v.wdata);
    end
    if (v.rst) begin
      cmp({tag, ".rst_im_addr"}, 32'(im_addr), 32'h0);
      cmp({tag, ".rst_dm_addr"}, 32'(dm_addr), 32'h0);
      cmp({tag, ".rst_im_wdata"}, im_wdata, 32'h0);
      cmp({tag, ".rst_dm_wdata"}, dm_wdata, 32'h0);
    end
  endtask

  initial begin
    vec_t rv;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; halt = 1'b0;
    repeat (2) @(negedge clk);
    rv = '{rst: 1, valid: 0, data: 0, halt: 0, rdy: 1, imwe: 0, dmwe: 0,
           addr: 0, wdata: 0, run: 0, err: 0};
    checkOutput(rv, -1);

`ifndef SBN_LOADER_CHKSUM_EN
    // Imem load, two words back to back.
    b(8'h01); b(8'h10); b(8'h02);
    b(8'h11); b(8'h22); b(8'h33); bi(8'h44, 8'h10, 32'h11223344);
    b(8'h55); b(8'h66); b(8'h77); bi(8'h88, 8'h11, 32'h55667788);
    idle();
    // Dmem load wrapping 0xFF -> 0x00; halt here must be ignored.
    b(8'h02); b(8'hFF); b(8'h02);
    b(8'h00); addv(0, 1, 8'h00, 1, 1, 0, 0, 8'h00, 32'h0, 0, 0);
    b(8'h00); bd(8'h05, 8'hFF, 32'h00000005);
    b(8'hFF); b(8'hFF); b(8'hFF); bd(8'hFF, 8'h00, 32'hFFFFFFFF);
    // Empty frame.
    b(8'h02); b(8'h20); b(8'h00); idle(); idle();
    // Run, offered bytes ignored, then halt.
    addv(0, 1, 8'h03, 0, 0, 0, 0, 8'h00, 32'h0, 1, 0);
    for (int i = 0; i < 3; i++) addv(0, 1, 8'h01, 0, 0, 0, 0, 8'h00, 32'h0, 1, 0);
    addv(0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 32'h0, 0, 0);
    idle();
    // Reset mid-word, then a fresh load.
    b(8'h01); b(8'h00); b(8'h01); b(8'hAA); b(8'hBB);
    rstv(); idle();
    b(8'h01); b(8'h00); b(8'h01);
    b(8'h01); b(8'h02); b(8'h03); bi(8'h04, 8'h00, 32'h01020304);
    idle();
`else
    // Run frame with checksum (03 + FD = 0x100).
    b(8'h03);
    addv(0, 1, 8'hFD, 0, 0, 0, 0, 8'h00, 32'h0, 1, 0);
    addv(0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 32'h0, 0, 0);
    // Good dmem frame.
    b(8'h02); b(8'h00); b(8'h01);
    b(8'h00); b(8'h00); b(8'h00); bd(8'h01, 8'h00, 32'h00000001);
    b(8'hFC); idle();
    // Empty frame with checksum.
    b(8'h02); b(8'h20); b(8'h00); b(8'hDE); idle();
    // Bad checksum: word still written, then err.
    b(8'h02); b(8'h00); b(8'h01);
    b(8'h00); b(8'h00); b(8'h00); bd(8'h01, 8'h00, 32'h00000001);
    addv(0, 1, 8'hFD, 0, 0, 0, 0, 8'h00, 32'h0, 0, 1);
    addv(0, 1, 8'h02, 0, 0, 0, 0, 8'h00, 32'h0, 0, 1);
    rstv(); idle();
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Unknown command locks the loader in error until reset.
    rv = '{rst: 0, valid: 1, data: 8'h07, halt: 0, rdy: 0, imwe: 0, dmwe: 0,
           addr: 0, wdata: 0, run: 0, err: 1};
    applyStimulus(rv);
    checkOutput(rv, 1000);
    rv.data = 8'h01;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(rv);
      checkOutput(rv, 1001 + i);
    end
    rv = '{rst: 1, valid: 0, data: 0, halt: 0, rdy: 1, imwe: 0, dmwe: 0,
           addr: 0, wdata: 0, run: 0, err: 0};
    applyStimulus(rv);
    checkOutput(rv, 1100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sbn_loader.md
Name: sbn_loader

Overview:
- Upstream stage of the SBN machine. Accepts a byte stream over a valid/ready handshake, decodes framed load commands, and writes whole words into the SBN instruction memory and data memory.
- Asserts run to release the machine once loading is complete, and drops it on halt.
- Replaces file-based memory preload in synthesizable builds.

Parameters:
fwidth, 8, SBN operand field width; address/count width; must be <= 8
dwidth, 32, data word width
IBYTES, (4*fwidth+7)/8, bytes per instruction word (derived, localparam)
DBYTES, (dwidth+7)/8, bytes per data word (derived, localparam)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_data  in  8  stream byte
in_valid  in  1  byte valid
in_ready  out  1  loader accepts byte
im_we  out  1  instruction memory write strobe, one cycle
im_addr  out  fwidth  instruction write address
im_wdata  out  4*fwidth  instruction write data
dm_we  out  1  data memory write strobe, one cycle
dm_addr  out  fwidth  data write address
dm_wdata  out  dwidth  data write data
run  out  1  machine enable
halt  in  1  machine finished; sampled only while run=1
err  out  1  sticky protocol error

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst). Reset takes priority over all other inputs, including mid-frame.
- Reset values: state=IDLE, in_ready=1, im_we=0, dm_we=0, addresses=0, wdata=0, run=0, err=0.
- Transfer rule: a byte is transferred when in_valid && in_ready at a rising clk edge.
- Frame format: CMD, ADDR, CNT, then CNT words. Each word is big-endian, IBYTES bytes (CMD=0x01) or DBYTES bytes (CMD=0x02).
- ADDR and CNT use their low fwidth bits. CNT=0 means no words; the frame ends after the CNT byte.
- FSM states and transitions:
  - IDLE: 0x01/0x02 -> ADDR; 0x03 -> RUN; any other byte -> ERR.
  - ADDR: latch start address -> CNT.
  - CNT: latch count; count=0 -> IDLE, else -> DATA.
  - DATA: shift bytes into an assembly register (MSB first); keep the low 4*fwidth or dwidth bits.
    - On the last byte of a word: next cycle pulse im_we or dm_we with the current address and the assembled word.
    - Then address increments modulo 2^fwidth (0xFF wraps to 0x00) and the word counter decrements.
    - After the last word -> IDLE.
  - RUN: run=1 from the cycle after the 0x03 byte is accepted; in_ready=0. halt=1 -> run=0 next cycle, state -> IDLE.
  - ERR: err=1, in_ready=0, no writes; exits only on rst.
- in_ready is 1 in IDLE, ADDR, CNT and DATA. There is no internal backpressure. Back-to-back bytes are sustained; a write strobe may coincide with the next byte being accepted.
- Write latency: exactly 1 cycle after the final byte of a word. im_we and dm_we are never high simultaneously.
- halt while run=0 is ignored.

Optional Feature:
SBN_LOADER_CHKSUM_EN
- Defined:
  - Every frame (CMD 0x01/0x02/0x03) carries a trailing checksum byte after its last word (or after CNT when CNT=0, or immediately after CMD 0x03).
  - The 8-bit sum of all frame bytes including the checksum must be 0x00. Match -> IDLE (or RUN for 0x03); mismatch -> ERR.
  - Words already written stay written; err flags the bad frame.
- Undefined: no checksum byte; transitions as above.

Decomposition:
- Package sbn_pkg holds:
  - state encoding enum (IDLE, ADDR, CNT, DATA, CHK, RUN, ERR);
  - command constants CMD_LDI=0x01, CMD_LDD=0x02, CMD_RUN=0x03;
  - default fwidth/dwidth.
- One natural sub-module: sbn_word_asm, a byte shift/assembly register with byte counter and word-complete pulse, parameterised by byte count and output width.

Test Plan:
- Imem load: 01 10 02 11 22 33 44 55 66 77 88 -> im_we at addr 0x10 data 0x11223344, then addr 0x11 data 0x55667788; each strobe 1 cycle after byte 0x44 / 0x88.
- Dmem wrap: 02 FF 02 00000005 FFFFFFFF -> dm_we addr 0xFF data 5, then addr 0x00 data 0xFFFFFFFF; CNT=0 frame 02 20 00 produces no writes.
- Run/halt: 03 -> run=1 next cycle, in_ready=0; bytes offered are not consumed. Pulse halt -> run=0 next cycle, in_ready=1.
- Bad command 07 -> err=1, in_ready=0, no strobes for 20 cycles; rst -> all reset values.
- Reset mid-word: 01 00 01 AA BB, then rst -> no im_we. Then 01 00 01 01 02 03 04 -> im_we addr 0 data 0x01020304.
- With SBN_LOADER_CHKSUM_EN: 02 00 01 00 00 00 01 FC -> dm_we addr 0 data 1, no err. Same frame with checksum FD -> dm_we still occurs, then err=1.
